if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 22 ++
 rtl/if_stage.sv | 145 ++++++++++++++
 tb/tb_if_stage.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory read port between the fetch stage and instruction memory.
// The fetch stage drives the request and address; memory returns ack and data.
interface if_stage_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory read, a one-entry skid buffer
// for downstream stalls, and redirects that drop any in-flight read.
module if_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   if_stage_if.master  mem,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state,     w_state_nxt;
   logic [31:0] r_fetch_pc,  w_fetch_pc_nxt;
   logic [31:0] r_mem_addr,  w_mem_addr_nxt;
   logic        r_mem_req,   w_mem_req_nxt;
   logic [31:0] r_pc,        w_pc_nxt;
   logic [31:0] r_inst,      w_inst_nxt;
   logic        r_valid,     w_valid_nxt;
   logic [31:0] r_buf_pc,    w_buf_pc_nxt;
   logic [31:0] r_buf_inst,  w_buf_inst_nxt;
   logic        r_drop,      w_drop_nxt;

   logic [31:0] w_jump_tgt;
   logic [31:0] w_fetch_pc_inc;
   logic        w_space;

   assign w_jump_tgt     = jump_addr_i & ~32'h3;
   assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
   assign w_space        = !r_valid || !stall_i;

   // NOTE: every next-state value gets a default first so no latch is inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_req_nxt  = r_mem_req;
      w_pc_nxt       = r_pc;
      w_inst_nxt     = r_inst;
      w_valid_nxt    = r_valid && stall_i;   // accepted output empties unless refilled
      w_buf_pc_nxt   = r_buf_pc;
      w_buf_inst_nxt = r_buf_inst;
      w_drop_nxt     = r_drop;

      if (jump_i) begin
         w_fetch_pc_nxt = w_jump_tgt;
         w_valid_nxt    = 1'b0;
         w_buf_pc_nxt   = 32'd0;
         w_buf_inst_nxt = 32'd0;
         // An unacked read cannot be abandoned: keep it on the bus and drop its data.
         if (r_state == S_REQ && !mem.mem_ack) begin
            w_drop_nxt = 1'b1;
         end else begin
            w_state_nxt    = S_REQ;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = w_jump_tgt;
            w_drop_nxt     = 1'b0;
         end
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_state_nxt    = S_REQ;
               w_mem_req_nxt  = 1'b1;
               w_mem_addr_nxt = r_fetch_pc;
            end
            S_REQ: begin
               if (mem.mem_ack) begin
                  if (r_drop) begin
                     w_drop_nxt     = 1'b0;
                     w_mem_addr_nxt = r_fetch_pc;
                  end else if (w_space) begin
                     w_pc_nxt       = r_mem_addr;
                     w_inst_nxt     = mem.mem_rdata;
                     w_valid_nxt    = 1'b1;
                     w_fetch_pc_nxt = w_fetch_pc_inc;
                     w_mem_addr_nxt = w_fetch_pc_inc;
                  end else begin
                     w_buf_pc_nxt   = r_mem_addr;
                     w_buf_inst_nxt = mem.mem_rdata;
                     w_fetch_pc_nxt = w_fetch_pc_inc;
                     w_mem_req_nxt  = 1'b0;
                     w_state_nxt    = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  w_pc_nxt       = r_buf_pc;
                  w_inst_nxt     = r_buf_inst;
                  w_valid_nxt    = 1'b1;
                  w_mem_req_nxt  = 1'b1;
                  w_mem_addr_nxt = r_fetch_pc;
                  w_state_nxt    = S_REQ;
               end
            end
            default: begin
               w_state_nxt   = S_IDLE;
               w_mem_req_nxt = 1'b0;
            end
         endcase
      end
   end

   // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fetch_pc <= 32'd0;
         r_mem_addr <= 32'd0;
         r_mem_req  <= 1'b0;
         r_pc       <= 32'd0;
         r_inst     <= 32'd0;
         r_valid    <= 1'b0;
         r_buf_pc   <= 32'd0;
         r_buf_inst <= 32'd0;
         r_drop     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_pc       <= w_pc_nxt;
         r_inst     <= w_inst_nxt;
         r_valid    <= w_valid_nxt;
         r_buf_pc   <= w_buf_pc_nxt;
         r_buf_inst <= w_buf_inst_nxt;
         r_drop     <= w_drop_nxt;
      end
   end

   assign mem.mem_req  = r_mem_req;
   assign mem.mem_addr = r_mem_addr;
   assign pc_o         = r_pc;
   assign inst_o       = r_inst;
   assign valid_o      = r_valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle sequences for the stall/redirect/reset corners,
// then table-driven runs against a memory model with a scoreboard of expected fetches.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        jump_i;
   logic [31:0] jump_addr_i;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;

   if_stage_if mem_bus ();

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .jump_i      (jump_i),
      .jump_addr_i (jump_addr_i),
      .mem         (mem_bus),
      .pc_o        (pc_o),
      .inst_o      (inst_o),
      .valid_o     (valid_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   typedef struct {
      logic        do_jump;
      logic [31:0] tgt;
      logic [31:0] exp_start;
      int          lat;
      int          stall_pct;
      logic        spur;
      int          n_inst;
   } vec_t;

   exp_t        sb_q[$];
   int          lat, stall_pct, wait_cnt, accepted;
   logic        spur, pend, jump_req;
   logic [31:0] pend_addr, jump_tgt, jump_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic sb_fill(input logic [31:0] start);
      logic [31:0] p;
      sb_q.delete();
      for (int i = 0; i < 64; i++) begin
         p = start + 32'(4 * i);
         sb_q.push_back('{pc: p, inst: mem_word(p)});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      stall_i = 1'b0;
      jump_i = 1'b0;
      jump_addr_i = 32'd0;
      mem_bus.mem_ack = 1'b0;
      mem_bus.mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req",   {31'd0, mem_bus.mem_req}, 32'd0);
      check("rst_addr",  mem_bus.mem_addr, 32'd0);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_pc",    pc_o, 32'd0);
      check("rst_inst",  inst_o, 32'd0);
      rst = 1'b0;
      pend = 1'b0;
      wait_cnt = 0;
      jump_req = 1'b0;
      sb_fill(32'd0);
   endtask

   // Drive one cycle's inputs at the falling edge, then advance to the next falling edge.
   task automatic cyc(input logic s, input logic j, input logic [31:0] ja,
                      input logic a, input logic [31:0] rd);
      stall_i = s;
      jump_i = j;
      jump_addr_i = ja;
      mem_bus.mem_ack = a;
      mem_bus.mem_rdata = rd;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_o(input string name, input logic e_req, input logic [31:0] e_addr,
                          input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_inst);
      check({name, "_req"}, {31'd0, mem_bus.mem_req}, {31'd0, e_req});
      if (e_req) check({name, "_addr"}, mem_bus.mem_addr, e_addr);
      check({name, "_valid"}, {31'd0, valid_o}, {31'd0, e_valid});
      if (e_valid) begin
         check({name, "_pc"}, pc_o, e_pc);
         check({name, "_inst"}, inst_o, e_inst);
      end
   endtask

   // Memory model plus scoreboard: serve reads with a fixed latency, pop one expected
   // fetch every cycle the output is accepted.
   task automatic cycle();
      logic        ack;
      logic [31:0] rd;
      exp_t        e;
      @(negedge clk);
      if (mem_bus.mem_req) begin
         if (pend) check("addr_stable", mem_bus.mem_addr, pend_addr);
         if (wait_cnt >= lat) begin
            ack = 1'b1;
            rd = mem_word(mem_bus.mem_addr);
            wait_cnt = 0;
         end else begin
            ack = 1'b0;
            rd = ~mem_word(mem_bus.mem_addr);
            wait_cnt++;
         end
         pend = !ack;
         pend_addr = mem_bus.mem_addr;
      end else begin
         ack = spur && ($urandom_range(0, 1) == 1);
         rd = 32'hDEADBEEF;
         pend = 1'b0;
         wait_cnt = 0;
      end
      mem_bus.mem_ack = ack;
      mem_bus.mem_rdata = rd;
      stall_i = ($urandom_range(0, 99) < stall_pct);
      jump_i = jump_req;
      jump_addr_i = jump_tgt;
      if (jump_req) begin
         sb_fill(jump_exp);
         jump_req = 1'b0;
      end else if (valid_o && !stall_i) begin
         if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("sb_pc", pc_o, e.pc);
            check("sb_inst", inst_o, e.inst);
         end
         accepted++;
      end
      @(posedge clk);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 0,  0, 1'b0,  8};
      vecs[1] = '{1'b1, 32'h0000_1000, 32'h0000_1000, 0,  0, 1'b0,  8};
      vecs[2] = '{1'b1, 32'h0000_2003, 32'h0000_2000, 2,  0, 1'b0,  6};
      vecs[3] = '{1'b1, 32'h0000_0301, 32'h0000_0300, 1, 30, 1'b1, 10};
      vecs[4] = '{1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFF0, 0, 25, 1'b0,  8};
      vecs[5] = '{1'b1, 32'h0000_0040, 32'h0000_0040, 3, 50, 1'b1,  8};
      lat = 0; stall_pct = 0; spur = 1'b0; accepted = 0;
      jump_tgt = 32'd0; jump_exp = 32'd0; pend_addr = 32'd0;

      do_reset();
      check("rel_idle_req", {31'd0, mem_bus.mem_req}, 32'd0);
      cyc(0, 0, 32'd0, 0, 32'd0);
      check_o("first_req", 1, 32'h0, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h1111_1111);
      check_o("stream0", 1, 32'h4, 1, 32'h0, 32'h1111_1111);
      cyc(0, 0, 32'd0, 1, 32'h2222_2222);
      check_o("stream1", 1, 32'h8, 1, 32'h4, 32'h2222_2222);

      // Stall for three cycles while the word at 0x8 returns.
      cyc(1, 0, 32'd0, 1, 32'h00A0_0093);
      check_o("hold0", 0, 32'd0, 1, 32'h4, 32'h2222_2222);
      cyc(1, 0, 32'd0, 1, 32'hBAD0_BAD0);
      check_o("hold1", 0, 32'd0, 1, 32'h4, 32'h2222_2222);
      cyc(1, 0, 32'd0, 0, 32'd0);
      check_o("hold2", 0, 32'd0, 1, 32'h4, 32'h2222_2222);
      cyc(0, 0, 32'd0, 0, 32'd0);
      check_o("unhold", 1, 32'hC, 1, 32'h8, 32'h00A0_0093);
      cyc(0, 0, 32'd0, 0, 32'd0);
      check_o("drain", 1, 32'hC, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h3333_3333);
      check_o("refill", 1, 32'h10, 1, 32'hC, 32'h3333_3333);

      // Redirect while the read at 0x10 is outstanding; ack two cycles later.
      cyc(0, 1, 32'h200, 0, 32'd0);
      check_o("jpend0", 1, 32'h10, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 0, 32'd0);
      check_o("jpend1", 1, 32'h10, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h5555_5555);
      check_o("jdrop", 1, 32'h200, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h7777_7777);
      check_o("jtgt", 1, 32'h204, 1, 32'h200, 32'h7777_7777);

      // Redirect in the ack cycle, unaligned target.
      cyc(0, 1, 32'h103, 1, 32'hCAFE_F00D);
      check_o("jack", 1, 32'h100, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h1234_5678);
      check_o("jack_tgt", 1, 32'h104, 1, 32'h100, 32'h1234_5678);

      // Two redirects while a read is pending: the last one wins.
      cyc(0, 1, 32'h400, 0, 32'd0);
      check_o("jj0", 1, 32'h104, 0, 32'd0, 32'd0);
      cyc(0, 1, 32'h500, 0, 32'd0);
      check_o("jj1", 1, 32'h104, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h0BAD_0BAD);
      check_o("jj_drop", 1, 32'h500, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h9999_9999);
      check_o("jj_tgt", 1, 32'h504, 1, 32'h500, 32'h9999_9999);

      // Redirect out of HOLD beats the stall and discards the buffer.
      cyc(1, 0, 32'd0, 1, 32'h9898_9898);
      check_o("hj_hold", 0, 32'd0, 1, 32'h500, 32'h9999_9999);
      cyc(1, 1, 32'h600, 0, 32'd0);
      check_o("hj_jump", 1, 32'h600, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'h6666_6666);
      check_o("hj_tgt", 1, 32'h604, 1, 32'h600, 32'h6666_6666);

      // Address wrap at the top of memory, then reset in the middle of a read.
      cyc(0, 1, 32'hFFFF_FFFC, 1, 32'h0BAD_0BAD);
      check_o("wrap_jump", 1, 32'hFFFF_FFFC, 0, 32'd0, 32'd0);
      cyc(0, 0, 32'd0, 1, 32'hF0F0_F0F0);
      check_o("wrap", 1, 32'h0, 1, 32'hFFFF_FFFC, 32'hF0F0_F0F0);
      rst = 1'b1;
      cyc(0, 0, 32'd0, 0, 32'd0);
      check("mid_rst_req",  {31'd0, mem_bus.mem_req}, 32'd0);
      check("mid_rst_addr", mem_bus.mem_addr, 32'd0);
      check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
      check("mid_rst_pc",   pc_o, 32'd0);
      check("mid_rst_inst", inst_o, 32'd0);
      rst = 1'b0;
      cyc(0, 0, 32'd0, 0, 32'd0);
      check_o("post_rst", 1, 32'h0, 0, 32'd0, 32'd0);

      // Table-driven runs: each row redirects (except the first) and streams n_inst fetches.
      do_reset();
      for (int v = 0; v < 6; v++) begin
         lat = vecs[v].lat;
         stall_pct = vecs[v].stall_pct;
         spur = vecs[v].spur;
         if (vecs[v].do_jump) begin
            jump_req = 1'b1;
            jump_tgt = vecs[v].tgt;
            jump_exp = vecs[v].exp_start;
         end
         accepted = 0;
         for (int c = 0; c < 400 && accepted < vecs[v].n_inst; c++) cycle();
         check($sformatf("vec%0d_done", v), (accepted >= vecs[v].n_inst) ? 32'd1 : 32'd0, 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
